// File: rtl/sample_div_pkg.sv
// Shared types and constants for the sample datapath sequential divider.
package sample_div_pkg;

  localparam int unsigned DIV_W = 14;
  localparam int unsigned CNT_W = 4;

  // Quotient forced for a zero divisor, and the wrapped quotient for -8192 / -1.
  localparam logic [DIV_W-1:0] DIV0_QUOT = 14'h3FFF;
  localparam logic [DIV_W-1:0] OVF_QUOT  = 14'h2000;

  // Counter value of the final (14th) iteration.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Two's complement negate at the datapath width.
  function automatic logic [DIV_W-1:0] neg(input logic [DIV_W-1:0] v);
    return ~v + DIV_W'(1);
  endfunction

  // Magnitude of a signed operand as unsigned; -8192 maps to 0x2000.
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? neg(v) : v;
  endfunction

endpackage

// File: rtl/sample_sdiv_14_seq_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module sample_sdiv_14_seq_step
  import sample_div_pkg::*;
(
  input  logic [DIV_W:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [DIV_W-1:0] dvs_mag,
  output logic [DIV_W:0]   rem_out,
  output logic             q_bit
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W+1:0] trial;

  // Partial remainder stays below the divisor, so the extra top bit never carries out.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {2'b00, dvs_mag};
    q_bit   = ~trial[DIV_W+1];
    rem_out = q_bit ? trial[DIV_W:0] : shifted[DIV_W:0];
  end

endmodule

// File: rtl/sample_sdiv_14_seq.sv
// Sequential signed 14-bit divider: magnitude restoring division, one
// quotient bit per enabled cycle, C-style sign fix-up, one-cycle done.
module sample_sdiv_14_seq
  import sample_div_pkg::*;
#(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd14,
  parameter int unsigned din1_WIDTH = 32'd14,
  parameter int unsigned dout_WIDTH = 32'd14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout_quot,
  output logic [dout_WIDTH-1:0] dout_rem,
  output logic                  div_by_zero,
  output logic                  overflow
);

  state_t           state;
  state_t           state_nx;

  logic [DIV_W-1:0] a_raw;     // original dividend (sign, div-by-zero remainder)
  logic [DIV_W-1:0] b_raw;     // original divisor (sign, special-case detect)
  logic [DIV_W-1:0] dvd_sh;    // dividend magnitude, MSB consumed each iteration
  logic [DIV_W-1:0] dvs_mag;
  logic [DIV_W-1:0] quot_mag;
  logic [DIV_W:0]   rem_part;
  logic [CNT_W-1:0] cnt;

  logic [DIV_W:0]   step_rem;
  logic             step_q;

  sample_sdiv_14_seq_step u_step (
    .rem_in  (rem_part),
    .dvd_bit (dvd_sh[DIV_W-1]),
    .dvs_mag (dvs_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register; ce low freezes the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nx;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? CALC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_raw       <= '0;
      b_raw       <= '0;
      dvd_sh      <= '0;
      dvs_mag     <= '0;
      quot_mag    <= '0;
      rem_part    <= '0;
      cnt         <= '0;
      dout_quot   <= '0;
      dout_rem    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (ce) begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_raw    <= din0;
            b_raw    <= din1;
            dvd_sh   <= mag(din0);
            dvs_mag  <= mag(din1);
            quot_mag <= '0;
            rem_part <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          rem_part <= step_rem;
          quot_mag <= {quot_mag[DIV_W-2:0], step_q};
          dvd_sh   <= {dvd_sh[DIV_W-2:0], 1'b0};
          cnt      <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (b_raw == '0) begin
            dout_quot   <= DIV0_QUOT;
            dout_rem    <= a_raw;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (a_raw == OVF_QUOT && b_raw == '1) begin
            dout_quot   <= OVF_QUOT;
            dout_rem    <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            dout_quot   <= (a_raw[DIV_W-1] ^ b_raw[DIV_W-1]) ? neg(quot_mag) : quot_mag;
            dout_rem    <= a_raw[DIV_W-1] ? neg(rem_part[DIV_W-1:0]) : rem_part[DIV_W-1:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sdiv_14_seq.sv
// Directed bench for sample_sdiv_14_seq with a result scoreboard.
module tb_sample_sdiv_14_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        start = 1'b0;
  logic [13:0] din0 = '0;
  logic [13:0] din1 = '0;
  logic        busy;
  logic        done;
  logic [13:0] dout_quot;
  logic [13:0] dout_rem;
  logic        div_by_zero;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [13:0] q;
    logic [13:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  sample_sdiv_14_seq #(
    .ID(32'd1),
    .din0_WIDTH(32'd14),
    .din1_WIDTH(32'd14),
    .dout_WIDTH(32'd14)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .start       (start),
    .din0        (din0),
    .din1        (din1),
    .busy        (busy),
    .done        (done),
    .dout_quot   (dout_quot),
    .dout_rem    (dout_rem),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference: C semantics on plain ints, with the two forced special cases.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (b == 0) begin
      e.q  = 14'h3FFF;
      e.r  = a[13:0];
      e.dz = 1'b1;
    end else if (a == -8192 && b == -1) begin
      e.q  = 14'h2000;
      e.r  = '0;
      e.ov = 1'b1;
    end else begin
      e.q = 14'(a / b);
      e.r = 14'(a % b);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a start for one cycle; returns at the negedge of cycle T+1.
  task automatic issue(input int a, input int b);
    @(negedge clk);
    din0  = 14'(a);
    din1  = 14'(b);
    start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles from T+1.
  task automatic wait_done(input string tag, input int first_n, input int exp_lat);
    int n;
    n = first_n;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_quot"}, dout_quot, e.q);
      chk({tag, "_rem"},  dout_rem,  e.r);
      chk({tag, "_dz"},   div_by_zero, e.dz);
      chk({tag, "_ovf"},  overflow,  e.ov);
    end
  endtask

  task automatic one_shot(input string tag, input int a, input int b);
    issue(a, b);
    wait_done(tag, 1, 16);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    int seen;

    // Reset state
    ce = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quot", dout_quot, 14'h0);
    chk("rst_rem",  dout_rem,  14'h0);
    chk("rst_dz",   div_by_zero, 1'b0);
    chk("rst_ovf",  overflow,  1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Basic and sign combinations
    one_shot("pp", 100, 7);
    one_shot("np", -100, 7);
    one_shot("pn", 100, -7);
    one_shot("nn", -100, -7);

    // Special cases
    one_shot("div0", 5, 0);
    one_shot("ovf", -8192, -1);
    one_shot("big", 8191, 3);
    one_shot("minpos", -8192, 1);

    // ce low for 3 cycles during CALC
    issue(100, 7);
    n = 1;
    repeat (3) begin @(negedge clk); n++; end
    ce = 1'b0;
    repeat (3) begin @(negedge clk); n++; end
    chk("ce_busy_frozen", busy, 1'b1);
    ce = 1'b1;
    wait_done("ce", n, 19);
    check_result("ce");
    ce = 1'b0;
    repeat (2) @(negedge clk);
    chk("ce_done_held", done, 1'b1);
    ce = 1'b1;
    @(negedge clk);
    chk("ce_done_one_enabled", done, 1'b0);

    // start ignored mid-operation, then back-to-back start while done
    issue(100, 7);
    n = 1;
    while (n < 5) begin @(negedge clk); n++; end
    din0  = 14'd1;
    din1  = 14'd1;
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    chk("ign_busy", busy, 1'b1);
    wait_done("b2b_first", n, 16);
    check_result("b2b_first");
    din0  = 14'd50;
    din1  = 14'd3;
    start = 1'b1;
    sb.push_back(model(50, 3));
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart_busy", busy, 1'b1);
    wait_done("b2b_second", 1, 16);
    check_result("b2b_second");
    @(negedge clk);

    // Reset mid-operation
    issue(100, 7);
    n = 1;
    while (n < 8) begin @(negedge clk); n++; end
    reset = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("mid_rst_quot", dout_quot, 14'h0);
    chk("mid_rst_rem",  dout_rem,  14'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_dz",   div_by_zero, 1'b0);
    chk("mid_rst_ovf",  overflow,  1'b0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    one_shot("after_rst", 9, 3);

    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
